collision_monitor: RTL and testbench
====================================

// Module: collision_monitor
// PURPOSE
//   Generates the active-low 'dead' request consumed by the game status block.
//   Watches per-pixel player/obstacle sprite coincidence during the VGA scan.
//   Filters glitch overlaps, keeps a lives counter and grants post-hit invulnerability frames.
//   Sits between the sprite renderers (pixel domain) and the status latch.
// PARAMETERS
//   LIVES         3   lives loaded on game start (1..15)
//   GRACE_FRAMES  60  invulnerable frames after a non-fatal hit (0..255; 0 = none)
//   MIN_OVERLAP   4   overlapping visible pixels in one frame that count as a hit (1..255)
// PORTS
//   clk          in   1  pixel clock
//   reset        in   1  reset, asynchronous, active-low
//   game_active  in   1  high while a game is in progress (status output)
//   frame_end    in   1  one-cycle pulse at start of vertical blank
//   pixel_valid  in   1  current pixel inside visible area
//   player_px    in   1  player sprite opaque at current pixel
//   obstacle_px  in   1  any obstacle opaque at current pixel
//   dead         out  1  active-low game-over request, registered
//   lives        out  4  remaining lives, registered
//   hit_flash    out  1  high during grace period (sprite blink), registered
// BEHAVIOUR
//   Reset values: state IDLE, dead=1, lives=LIVES, hit_flash=0.
//   Reset values: overlap_cnt=0, grace_cnt=0. Reset mid-operation applies immediately.
//   ovl = pixel_valid & player_px & obstacle_px.
//   overlap_cnt: 8-bit, saturates at MIN_OVERLAP. Cleared on every frame_end.
//   States:
//   - IDLE: lives=LIVES, dead=1.
//     game_active=1 -> RUN; overlap_cnt cleared.
//   - RUN: overlap_cnt += ovl (saturating).
//     On frame_end, hit = (overlap_cnt + ovl) >= MIN_OVERLAP.
//     An ovl coincident with frame_end counts toward the closing frame.
//     hit & lives==1 -> OVER, lives=0.
//     hit & lives>1 & GRACE_FRAMES>0 -> GRACE, lives-1, grace_cnt=GRACE_FRAMES, hit_flash=1.
//     hit & lives>1 & GRACE_FRAMES==0 -> stay RUN, lives-1.
//     No hit -> stay RUN.
//   - GRACE: ovl ignored; overlap_cnt held 0.
//     Each frame_end decrements grace_cnt.
//     Frame_end with grace_cnt==1 -> RUN, hit_flash=0.
//   - OVER: dead=0, hit_flash=0, lives=0 held.
//     game_active=0 -> IDLE; dead returns to 1.
//     Minimum dead-low width: 1 cycle.
//   game_active falling while in RUN or GRACE -> IDLE: lives reload, hit_flash=0, dead stays 1.
//   Precedence: async reset > game_active falling > frame_end evaluation.
//   Latency: all outputs update on the clk edge that samples frame_end (visible next cycle).
//   dead is never low in IDLE/RUN/GRACE; each game end gives exactly one falling edge.
// CONFIGURATION
//   COLLISION_HITCNT_EN defined:
//   - Adds output hit_count[7:0]: total hits since reset, fatal hit included, saturating at 255.
//   - Not cleared by game restart; cleared only by reset.
//   COLLISION_HITCNT_EN undefined:
//   - Port and counter absent; all other behaviour identical.
// TESTING
//   1. Reset, game_active=1, 5 frames with no ovl -> lives=3, dead=1, hit_flash=0 throughout.
//   2a. 3 ovl pixels in one frame -> lives stays 3.
//   2b. 4 ovl pixels in next frame -> lives=2, hit_flash=1 cycle after frame_end.
//   3. After hit, 10 ovl/frame for 60 frames -> lives stays 2; hit_flash=0 after 60th frame_end.
//   4a. Third hit -> dead=0, lives=0 one cycle after frame_end.
//   4b. Drop game_active -> dead=1, lives=3 next cycle.
//   5a. MIN_OVERLAP=1, single ovl on the frame_end cycle -> counted as hit.
//   5b. Reset pulse mid-GRACE -> all reset values asynchronously.
//   6. COLLISION_HITCNT_EN, GRACE_FRAMES=0, 300 hit frames over restarts -> hit_count saturates at 255.

Source files
------------

// File: rtl/collision_monitor_if.sv
// rtl/collision_monitor_if.sv - sprite/status signal bundle for collision_monitor (hit_count present with COLLISION_HITCNT_EN)
interface collision_monitor_if;
  logic       game_active;
  logic       frame_end;
  logic       pixel_valid;
  logic       player_px;
  logic       obstacle_px;
  logic       dead;
  logic [3:0] lives;
  logic       hit_flash;
`ifdef COLLISION_HITCNT_EN
  logic [7:0] hit_count;
`endif

  // Video timing / sprite side drives the pixel stream and sees the status outputs
  modport master (
    output game_active, frame_end, pixel_valid, player_px, obstacle_px,
`ifdef COLLISION_HITCNT_EN
    input  hit_count,
`endif
    input  dead, lives, hit_flash
  );

  // The monitor itself
  modport slave (
    input  game_active, frame_end, pixel_valid, player_px, obstacle_px,
`ifdef COLLISION_HITCNT_EN
    output hit_count,
`endif
    output dead, lives, hit_flash
  );
endinterface

// File: rtl/collision_monitor.sv
// rtl/collision_monitor.sv - player/obstacle collision filter, lives counter and grace timer (optional COLLISION_HITCNT_EN hit counter)
module collision_monitor #(
  parameter int LIVES        = 3,
  parameter int GRACE_FRAMES = 60,
  parameter int MIN_OVERLAP  = 4
) (
  input  logic                clk,
  input  logic                reset,
  collision_monitor_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, GRACE, OVER} state_t;

  localparam logic [3:0] LIVES_INIT = 4'(LIVES);
  localparam logic [7:0] GRACE_INIT = 8'(GRACE_FRAMES);
  localparam logic [8:0] MIN_OVL    = 9'(MIN_OVERLAP);
  localparam bit         HAS_GRACE  = (GRACE_FRAMES > 0);

  state_t     state, state_nx;
  logic [7:0] overlap_cnt, overlap_nx;
  logic [7:0] grace_cnt, grace_nx;
  logic [3:0] lives_q, lives_nx;
  logic       dead_q, dead_nx;
  logic       flash_q, flash_nx;

  logic       ovl;
  logic [8:0] ovl_sum;
  logic [7:0] ovl_sat;
  logic       hit;
  logic       hit_event;

  // A coincident overlap on the frame_end cycle still belongs to the closing frame,
  // so the hit decision uses the count including the current pixel.
  assign ovl       = bus.pixel_valid & bus.player_px & bus.obstacle_px;
  assign ovl_sum   = {1'b0, overlap_cnt} + {8'd0, ovl};
  assign hit       = (ovl_sum >= MIN_OVL);
  assign ovl_sat   = hit ? MIN_OVL[7:0] : ovl_sum[7:0];
  assign hit_event = (state == RUN) & bus.game_active & bus.frame_end & hit;

  // State and registered outputs; reset takes effect without waiting for a clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      overlap_cnt <= 8'd0;
      grace_cnt   <= 8'd0;
      lives_q     <= LIVES_INIT;
      dead_q      <= 1'b1;
      flash_q     <= 1'b0;
    end else begin
      state       <= state_nx;
      overlap_cnt <= overlap_nx;
      grace_cnt   <= grace_nx;
      lives_q     <= lives_nx;
      dead_q      <= dead_nx;
      flash_q     <= flash_nx;
    end
  end

  // Next-state: game_active falling wins over any frame_end evaluation
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.game_active) state_nx = RUN;
      RUN: begin
        if (!bus.game_active) begin
          state_nx = IDLE;
        end else if (bus.frame_end && hit) begin
          if (lives_q <= 4'd1)  state_nx = OVER;
          else if (HAS_GRACE)   state_nx = GRACE;
        end
      end
      GRACE: begin
        if (!bus.game_active)                       state_nx = IDLE;
        else if (bus.frame_end && grace_cnt <= 8'd1) state_nx = RUN;
      end
      OVER:  if (!bus.game_active) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the counters and registered outputs
  always_comb begin
    overlap_nx = overlap_cnt;
    grace_nx   = grace_cnt;
    lives_nx   = lives_q;
    dead_nx    = dead_q;
    flash_nx   = flash_q;
    case (state)
      IDLE: begin
        overlap_nx = 8'd0;
        grace_nx   = 8'd0;
        lives_nx   = LIVES_INIT;
        dead_nx    = 1'b1;
        flash_nx   = 1'b0;
      end
      RUN: begin
        if (!bus.game_active) begin
          overlap_nx = 8'd0;
          lives_nx   = LIVES_INIT;
          flash_nx   = 1'b0;
        end else if (bus.frame_end) begin
          overlap_nx = 8'd0;
          if (hit) begin
            if (lives_q <= 4'd1) begin
              lives_nx = 4'd0;
              dead_nx  = 1'b0;
              flash_nx = 1'b0;
            end else begin
              lives_nx = lives_q - 4'd1;
              if (HAS_GRACE) begin
                grace_nx = GRACE_INIT;
                flash_nx = 1'b1;
              end
            end
          end
        end else begin
          overlap_nx = ovl_sat;
        end
      end
      GRACE: begin
        overlap_nx = 8'd0;
        if (!bus.game_active) begin
          grace_nx = 8'd0;
          lives_nx = LIVES_INIT;
          flash_nx = 1'b0;
        end else if (bus.frame_end) begin
          if (grace_cnt <= 8'd1) begin
            grace_nx = 8'd0;
            flash_nx = 1'b0;
          end else begin
            grace_nx = grace_cnt - 8'd1;
          end
        end
      end
      OVER: begin
        overlap_nx = 8'd0;
        flash_nx   = 1'b0;
        if (!bus.game_active) begin
          dead_nx  = 1'b1;
          lives_nx = LIVES_INIT;
        end else begin
          dead_nx  = 1'b0;
          lives_nx = 4'd0;
        end
      end
      default: begin
        overlap_nx = 8'd0;
        grace_nx   = 8'd0;
        lives_nx   = LIVES_INIT;
        dead_nx    = 1'b1;
        flash_nx   = 1'b0;
      end
    endcase
  end

  assign bus.dead      = dead_q;
  assign bus.lives     = lives_q;
  assign bus.hit_flash = flash_q;

`ifdef COLLISION_HITCNT_EN
  logic [7:0] hit_cnt;

  // Lifetime hit tally, survives game restarts, sticks at 255
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              hit_cnt <= 8'd0;
    else if (hit_event && hit_cnt != 8'hFF)  hit_cnt <= hit_cnt + 8'd1;
  end

  assign bus.hit_count = hit_cnt;
`else
  logic unused_hit_event;
  assign unused_hit_event = hit_event;
`endif

endmodule

// File: tb/tb_collision_monitor.sv
// tb/tb_collision_monitor.sv - self-checking bench for collision_monitor
module tb_collision_monitor;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  collision_monitor_if ifc ();
  collision_monitor_if ifc_b ();

  collision_monitor #(.LIVES(3), .GRACE_FRAMES(60), .MIN_OVERLAP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  collision_monitor #(.LIVES(3), .GRACE_FRAMES(0), .MIN_OVERLAP(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc_b)
  );

  typedef struct {
    int rep;
    int n_ovl;
    bit on_end;
    int lives;
    int dead;
    int flash;
  } vec_t;

  typedef struct {
    int    lives;
    int    dead;
    int    flash;
    string name;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame on the main DUT: n_ovl counted overlaps, masked and single-sprite
  // pixels that must not count, then frame_end (optionally overlapping / dropping game_active)
  task automatic drive_frame(input string name, input int n_ovl, input bit on_end, input bit ga_end,
                             input int e_lives, input int e_dead, input int e_flash);
    exp_t e;
    exp_t got;
    for (int i = 0; i < n_ovl; i++) begin
      ifc.pixel_valid = 1'b1; ifc.player_px = 1'b1; ifc.obstacle_px = 1'b1;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      ifc.pixel_valid = 1'b0; ifc.player_px = 1'b1; ifc.obstacle_px = 1'b1;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      ifc.pixel_valid = 1'b1; ifc.player_px = 1'b1; ifc.obstacle_px = 1'b0;
      tick();
    end
    ifc.pixel_valid = on_end; ifc.player_px = on_end; ifc.obstacle_px = on_end;
    ifc.frame_end   = 1'b1;
    ifc.game_active = ga_end;
    e.lives = e_lives; e.dead = e_dead; e.flash = e_flash; e.name = name;
    sb.push_back(e);
    tick();
    ifc.frame_end = 1'b0;
    ifc.pixel_valid = 1'b0; ifc.player_px = 1'b0; ifc.obstacle_px = 1'b0;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty at output", name);
    end else begin
      got = sb.pop_front();
      check({got.name, ".lives"}, int'(ifc.lives), got.lives);
      check({got.name, ".dead"},  int'(ifc.dead),  got.dead);
      check({got.name, ".flash"}, int'(ifc.hit_flash), got.flash);
    end
  endtask

  // One frame on dut_b whose only overlap sits on the frame_end cycle
  task automatic b_frame(input bit with_ovl);
    ifc_b.pixel_valid = with_ovl; ifc_b.player_px = with_ovl; ifc_b.obstacle_px = with_ovl;
    ifc_b.frame_end = 1'b1;
    tick();
    ifc_b.frame_end = 1'b0;
    ifc_b.pixel_valid = 1'b0; ifc_b.player_px = 1'b0; ifc_b.obstacle_px = 1'b0;
  endtask

  initial begin
    int hits;
    int mlives;

    vecs[0] = '{5,  0,  1'b0, 3, 1, 0};
    vecs[1] = '{1,  3,  1'b0, 3, 1, 0};
    vecs[2] = '{1,  4,  1'b0, 2, 1, 1};
    vecs[3] = '{59, 10, 1'b0, 2, 1, 1};
    vecs[4] = '{1,  10, 1'b0, 2, 1, 0};
    vecs[5] = '{1,  3,  1'b1, 1, 1, 1};
    vecs[6] = '{59, 0,  1'b0, 1, 1, 1};
    vecs[7] = '{1,  0,  1'b0, 1, 1, 0};
    vecs[8] = '{1,  4,  1'b0, 0, 0, 0};

    ifc.game_active = 1'b0; ifc.frame_end = 1'b0;
    ifc.pixel_valid = 1'b0; ifc.player_px = 1'b0; ifc.obstacle_px = 1'b0;
    ifc_b.game_active = 1'b0; ifc_b.frame_end = 1'b0;
    ifc_b.pixel_valid = 1'b0; ifc_b.player_px = 1'b0; ifc_b.obstacle_px = 1'b0;

    repeat (2) tick();
    @(negedge clk);
    check("rst.lives", int'(ifc.lives), 3);
    check("rst.dead",  int'(ifc.dead), 1);
    check("rst.flash", int'(ifc.hit_flash), 0);
    check("rst_b.lives", int'(ifc_b.lives), 3);
    reset = 1'b1;
    ifc.game_active = 1'b1;
    tick();

    for (int i = 0; i < 9; i++)
      for (int r = 0; r < vecs[i].rep; r++)
        drive_frame($sformatf("v%0d.%0d", i, r), vecs[i].n_ovl, vecs[i].on_end, 1'b1,
                    vecs[i].lives, vecs[i].dead, vecs[i].flash);

    repeat (3) tick();
    check("over_hold.dead",  int'(ifc.dead), 0);
    check("over_hold.lives", int'(ifc.lives), 0);
    ifc.game_active = 1'b0;
    tick();
    check("restart.dead",  int'(ifc.dead), 1);
    check("restart.lives", int'(ifc.lives), 3);
    check("restart.flash", int'(ifc.hit_flash), 0);

    ifc.game_active = 1'b1;
    tick();
    drive_frame("prec_ga_drop", 4, 1'b0, 1'b0, 3, 1, 0);
    ifc.game_active = 1'b1;
    tick();
    drive_frame("grace_entry", 4, 1'b0, 1'b1, 2, 1, 1);
    for (int i = 0; i < 3; i++)
      drive_frame($sformatf("grace_f%0d", i), 6, 1'b0, 1'b1, 2, 1, 1);

    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst.lives", int'(ifc.lives), 3);
    check("async_rst.dead",  int'(ifc.dead), 1);
    check("async_rst.flash", int'(ifc.hit_flash), 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    drive_frame("post_rst_hit", 4, 1'b0, 1'b1, 2, 1, 1);
    check("sb_drained", sb.size(), 0);

    ifc_b.game_active = 1'b1;
    tick();
    b_frame(1'b1);
    check("b_edge_ovl.lives", int'(ifc_b.lives), 2);
    check("b_edge_ovl.flash", int'(ifc_b.hit_flash), 0);
    check("b_edge_ovl.dead",  int'(ifc_b.dead), 1);
    b_frame(1'b0);
    check("b_noovl.lives", int'(ifc_b.lives), 2);
    hits = 1;
    mlives = 2;
    while (hits < 300) begin
      b_frame(1'b1);
      hits++;
      mlives--;
      check($sformatf("b_hit%0d.lives", hits), int'(ifc_b.lives), mlives);
`ifdef COLLISION_HITCNT_EN
      check($sformatf("b_hit%0d.count", hits), int'(ifc_b.hit_count), (hits > 255) ? 255 : hits);
`endif
      if (mlives == 0) begin
        check($sformatf("b_over%0d.dead", hits), int'(ifc_b.dead), 0);
        ifc_b.game_active = 1'b0;
        tick();
        check($sformatf("b_idle%0d.dead", hits), int'(ifc_b.dead), 1);
        ifc_b.game_active = 1'b1;
        tick();
        mlives = 3;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
